// File: rtl/wave_key_ctrl.sv
// wave_key_ctrl: turns debounced SEL/UP/DOWN key events into waveform type, edit field,
// frequency and amplitude indices with long-press toggle, auto-repeat and an update strobe.
module wave_key_ctrl #(
  parameter int LONG_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int FREQ_MIN   = 1,
  parameter int FREQ_MAX   = 100,
  parameter int FREQ_RST   = 10,
  parameter int AMP_MIN    = 1,
  parameter int AMP_MAX    = 15,
  parameter int AMP_RST    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] key_flag,
  input  logic [2:0] key_state,
  output logic [1:0] wave_type,
  output logic       edit_field,
  output logic [6:0] freq_idx,
  output logic [3:0] amp_idx,
  output logic       param_upd
);
  localparam int CMAX = LONG_CYC > REPEAT_CYC ? LONG_CYC : REPEAT_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] L_END = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] R_END = CW'(REPEAT_CYC - 1);
  localparam logic [6:0] F_MIN = 7'(FREQ_MIN);
  localparam logic [6:0] F_MAX = 7'(FREQ_MAX);
  localparam logic [3:0] A_MIN = 4'(AMP_MIN);
  localparam logic [3:0] A_MAX = 4'(AMP_MAX);

  typedef enum logic {S_IDLE, S_HELD} sel_st_e;
  typedef enum logic [1:0] {A_IDLE, A_HOLD, A_REPEAT} adj_st_e;

  sel_st_e sel_q, sel_d;
  adj_st_e adj_q, adj_d;
  logic [CW-1:0] sel_cnt_q, sel_cnt_d, adj_cnt_q, adj_cnt_d;
  logic long_q, long_d, own_q, own_d;
  logic [1:0] wave_q, wave_d;
  logic edit_q, edit_d, upd_q, upd_d;
  logic [6:0] freq_q, freq_d;
  logic [3:0] amp_q, amp_d;
  logic [2:0] press, rel;
  logic own_rel, step;

  assign press   = key_flag & ~key_state;
  assign rel     = key_flag & key_state;
  assign own_rel = own_q ? rel[2] : rel[1];

  always_comb begin
    sel_d     = sel_q;
    sel_cnt_d = sel_cnt_q;
    long_d    = long_q;
    wave_d    = wave_q;
    edit_d    = edit_q;
    adj_d     = adj_q;
    adj_cnt_d = adj_cnt_q;
    own_d     = own_q;
    step      = 1'b0;
    if (sel_q == S_IDLE) begin
      if (press[0]) begin
        sel_d     = S_HELD;
        sel_cnt_d = '0;
        long_d    = 1'b0;
      end
    end else if (rel[0]) begin
      sel_d  = S_IDLE;
      wave_d = long_q ? wave_q : wave_q + 2'd1;
    end else begin
      sel_cnt_d = sel_cnt_q == L_END ? sel_cnt_q : sel_cnt_q + 1'b1;
      if (sel_cnt_q == L_END && !long_q) begin
        edit_d = ~edit_q;
        long_d = 1'b1;
      end
    end
    case (adj_q)
      A_IDLE: if (press[1] | press[2]) begin
        own_d     = ~press[1];
        step      = 1'b1;
        adj_d     = A_HOLD;
        adj_cnt_d = '0;
      end
      A_HOLD: if (own_rel) adj_d = A_IDLE;
      else if (adj_cnt_q == L_END) begin
        step      = 1'b1;
        adj_d     = A_REPEAT;
        adj_cnt_d = '0;
      end else adj_cnt_d = adj_cnt_q + 1'b1;
      A_REPEAT: if (own_rel) adj_d = A_IDLE;
      else if (adj_cnt_q == R_END) begin
        step      = 1'b1;
        adj_cnt_d = '0;
      end else adj_cnt_d = adj_cnt_q + 1'b1;
      default: adj_d = A_IDLE;
    endcase
    // steps target the field selected before any same-cycle toggle
    freq_d = step && !edit_q ? (own_d ? (freq_q > F_MIN ? freq_q - 7'd1 : freq_q)
                                      : (freq_q < F_MAX ? freq_q + 7'd1 : freq_q)) : freq_q;
    amp_d  = step && edit_q ? (own_d ? (amp_q > A_MIN ? amp_q - 4'd1 : amp_q)
                                     : (amp_q < A_MAX ? amp_q + 4'd1 : amp_q)) : amp_q;
    upd_d  = wave_d != wave_q || edit_d != edit_q || freq_d != freq_q || amp_d != amp_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= S_IDLE;
      adj_q     <= A_IDLE;
      sel_cnt_q <= '0;
      adj_cnt_q <= '0;
      long_q    <= 1'b0;
      own_q     <= 1'b0;
      wave_q    <= 2'd0;
      edit_q    <= 1'b0;
      freq_q    <= 7'(FREQ_RST);
      amp_q     <= 4'(AMP_RST);
      upd_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      adj_q     <= adj_d;
      sel_cnt_q <= sel_cnt_d;
      adj_cnt_q <= adj_cnt_d;
      long_q    <= long_d;
      own_q     <= own_d;
      wave_q    <= wave_d;
      edit_q    <= edit_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      upd_q     <= upd_d;
    end
  end

  assign wave_type  = wave_q;
  assign edit_field = edit_q;
  assign freq_idx   = freq_q;
  assign amp_idx    = amp_q;
  assign param_upd  = upd_q;
endmodule
